// File: rtl/mux_pkg.sv
// Shared definitions for the registered N:1 word mux: mode encodings and
// the select-width helper used to size column ports.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_SCAN  = 1'b1;

    // Smallest w with 2**w >= n (clog2), usable in parameter defaults.
    function automatic int sel_width(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/mux_n_core.sv
// Combinational NUM_IN:1 select of WIDTH-bit words. Selects at or above
// NUM_IN return a zero word with range_err set.
module mux_n_core
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 16,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        word,
    output logic                    range_err
);

    always_comb begin
        word      = '0;
        range_err = 1'b1;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                word      = in_data[i*WIDTH +: WIDTH];
                range_err = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N:1 word mux with a single-entry valid/ready output stage and
// an auto-scan column counter that advances once per accepted transfer.
module mux_n_reg
    import mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 16,
    parameter int SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        column,
    input  logic                    mode,
    input  logic                    scan_restart,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_col,
    output logic                    sel_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam logic [SEL_W-1:0] LAST_COL = SEL_W'(NUM_IN - 1);

    logic [SEL_W-1:0] scan_cnt;
    logic [SEL_W-1:0] eff_col;
    logic [WIDTH-1:0] sel_word;
    logic             sel_range_err;
    logic             accept;

    // Ready passes straight through while the held word drains.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign eff_col  = (mode == MODE_SCAN) ? scan_cnt : column;

    mux_n_core #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_core (
        .in_data   (in_data),
        .sel       (eff_col),
        .word      (sel_word),
        .range_err (sel_range_err)
    );

    // Output stage: capture on accept, otherwise drain or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_col   <= '0;
            sel_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_word;
            out_col   <= eff_col;
            sel_err   <= sel_range_err;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Restart wins over advance; the same-cycle capture already used the old count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
        end else if (scan_restart) begin
            scan_cnt <= '0;
        end else if (accept && (mode == MODE_SCAN)) begin
            scan_cnt <= (scan_cnt == LAST_COL) ? '0 : scan_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mux_n_reg.sv
// Bench for mux_n_reg: a 16-input and a 12-input instance, directed vector
// table, hand-written corner sequences and randomized traffic vs a model.
module tb_mux_n_reg;

    localparam int W  = 32;
    localparam int NA = 16;
    localparam int NB = 12;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [NA*W-1:0] in_a;
    logic [3:0]      col_a;
    logic            mode_a, rs_a, iv_a, ordy_a;
    logic            ir_a, ov_a, err_a;
    logic [W-1:0]    od_a;
    logic [3:0]      oc_a;

    logic [NB*W-1:0] in_b;
    logic [3:0]      col_b;
    logic            mode_b, rs_b, iv_b, ordy_b;
    logic            ir_b, ov_b, err_b;
    logic [W-1:0]    od_b;
    logic [3:0]      oc_b;

    always #5 clk = ~clk;

    mux_n_reg #(.WIDTH(W), .NUM_IN(NA)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(in_a), .column(col_a), .mode(mode_a),
        .scan_restart(rs_a), .in_valid(iv_a), .in_ready(ir_a), .out_data(od_a),
        .out_col(oc_a), .sel_err(err_a), .out_valid(ov_a), .out_ready(ordy_a)
    );

    mux_n_reg #(.WIDTH(W), .NUM_IN(NB)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(in_b), .column(col_b), .mode(mode_b),
        .scan_restart(rs_b), .in_valid(iv_b), .in_ready(ir_b), .out_data(od_b),
        .out_col(oc_b), .sel_err(err_b), .out_valid(ov_b), .out_ready(ordy_b)
    );

    // Reference model: what the output stage should hold, in plain ints.
    typedef struct {
        bit          v;
        logic [31:0] data;
        int          col;
        bit          err;
        int          cnt;
    } mdl_t;

    typedef struct {
        bit       mode;
        logic [3:0] col;
        bit       iv;
        bit       ordy;
        bit       rs;
        bit       exp_ready;
        bit       exp_valid;
        int       exp_col;
    } vec_t;

    mdl_t m_a, m_b;
    vec_t tbl [14];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.v = 0; r.data = '0; r.col = 0; r.err = 0; r.cnt = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_next(mdl_t m, int n, bit mode, int column, bit iv,
                                      bit ordy, bit rs, logic [NA*W-1:0] flat);
        mdl_t r;
        bit   acc;
        int   c;
        r   = m;
        acc = iv && (!m.v || ordy);
        c   = mode ? m.cnt : column;
        if (acc) begin
            r.v    = 1;
            r.col  = c;
            r.err  = (c >= n);
            r.data = (c < n) ? flat[c*W +: W] : 32'd0;
        end else if (m.v && ordy) begin
            r.v = 0;
        end
        if (rs) r.cnt = 0;
        else if (acc && mode) r.cnt = (m.cnt + 1) % n;
        return r;
    endfunction

    task automatic check_outs();
        chk("a_out_valid", 32'(ov_a), 32'(m_a.v));
        chk("a_out_data", od_a, m_a.data);
        chk("a_out_col", 32'(oc_a), m_a.col);
        chk("a_sel_err", 32'(err_a), 32'(m_a.err));
        chk("b_out_valid", 32'(ov_b), 32'(m_b.v));
        chk("b_out_data", od_b, m_b.data);
        chk("b_out_col", 32'(oc_b), m_b.col);
        chk("b_sel_err", 32'(err_b), 32'(m_b.err));
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        #1;
        chk("a_in_ready", 32'(ir_a), 32'(!m_a.v || ordy_a));
        chk("b_in_ready", 32'(ir_b), 32'(!m_b.v || ordy_b));
        @(posedge clk);
        m_a = mdl_next(m_a, NA, mode_a, int'(col_a), iv_a, ordy_a, rs_a, in_a);
        m_b = mdl_next(m_b, NB, mode_b, int'(col_b), iv_b, ordy_b, rs_b, (NA*W)'(in_b));
        @(negedge clk);
        check_outs();
    endtask

    task automatic drive_a(input bit mode, input logic [3:0] col, input bit iv,
                           input bit ordy, input bit rs);
        mode_a = mode; col_a = col; iv_a = iv; ordy_a = ordy; rs_a = rs;
    endtask

    task automatic drive_b(input bit mode, input logic [3:0] col, input bit iv,
                           input bit ordy, input bit rs);
        mode_b = mode; col_b = col; iv_b = iv; ordy_b = ordy; rs_b = rs;
    endtask

    task automatic fill_words(input bit rnd);
        for (int i = 0; i < NA; i++) in_a[i*W +: W] = rnd ? $urandom : {16'hDEAD, 16'(i)};
        for (int i = 0; i < NB; i++) in_b[i*W +: W] = rnd ? $urandom : {16'hBEEF, 16'(i)};
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'd5,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5};
        tbl[1]  = '{1'b0, 4'd2,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2};
        tbl[2]  = '{1'b0, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[3]  = '{1'b0, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[4]  = '{1'b0, 4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2};
        tbl[5]  = '{1'b0, 4'd9,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 9};
        tbl[6]  = '{1'b0, 4'd9,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 9};
        tbl[7]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 9};
        tbl[8]  = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[9]  = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};
        tbl[10] = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        tbl[11] = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 0};
        tbl[12] = '{1'b0, 4'd15, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 15};
        tbl[13] = '{1'b1, 4'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1};

        fill_words(1'b0);
        drive_a(1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        drive_b(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        m_a = mdl_reset();
        m_b = mdl_reset();

        // Power-on reset with a request pending: nothing may be captured.
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(ov_a), 32'd0);
        chk("rst_out_data", od_a, 32'd0);
        chk("rst_out_col", 32'(oc_a), 32'd0);
        chk("rst_sel_err", 32'(err_a), 32'd0);
        chk("rst_in_ready", 32'(ir_a), 32'd1);
        rst_n = 1'b1;

        // Directed vector table on the 16-input instance.
        for (int k = 0; k < 14; k++) begin
            drive_a(tbl[k].mode, tbl[k].col, tbl[k].iv, tbl[k].ordy, tbl[k].rs);
            #1;
            chk($sformatf("tbl%0d_ready", k), 32'(ir_a), 32'(tbl[k].exp_ready));
            tick();
            chk($sformatf("tbl%0d_valid", k), 32'(ov_a), 32'(tbl[k].exp_valid));
            chk($sformatf("tbl%0d_col", k), 32'(oc_a), tbl[k].exp_col);
            chk($sformatf("tbl%0d_data", k), od_a, {16'hDEAD, 16'(tbl[k].exp_col)});
            chk($sformatf("tbl%0d_err", k), 32'(err_a), 32'd0);
        end

        // Reset while a word is held under backpressure: it vanishes at once.
        drive_a(1'b0, 4'd4, 1'b1, 1'b0, 1'b0);
        tick();
        chk("pre_rst_valid", 32'(ov_a), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(ov_a), 32'd0);
        chk("mid_rst_data", od_a, 32'd0);
        chk("mid_rst_ready", 32'(ir_a), 32'd1);
        m_a = mdl_reset();
        m_b = mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_a(1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
        tick();
        chk("post_rst_valid", 32'(ov_a), 32'd1);
        chk("post_rst_data", od_a, 32'hDEAD_0005);
        chk("post_rst_col", 32'(oc_a), 32'd5);

        // Scan wrap: 18 back-to-back transfers starting from the reset count.
        for (int i = 0; i < 18; i++) begin
            drive_a(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
            tick();
            chk("scan_col", 32'(oc_a), i % 16);
            chk("scan_valid", 32'(ov_a), 32'd1);
        end

        // Restart colliding with an accept at count 7.
        drive_a(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 7; i++) begin
            drive_a(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        drive_a(1'b1, 4'd0, 1'b1, 1'b1, 1'b1);
        tick();
        chk("restart_same_col", 32'(oc_a), 32'd7);
        drive_a(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("restart_next_col", 32'(oc_a), 32'd0);

        // Fixed-mode traffic leaves the scan count alone.
        drive_a(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b0, 4'($urandom_range(0, 15)), 1'b1, 1'b1, 1'b0);
            tick();
            chk("fixed_col", 32'(oc_a), 32'(col_a));
        end
        drive_a(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
        tick();
        chk("mode_back_col", 32'(oc_a), 32'd4);
        drive_a(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);

        // Out-of-range selects on the 12-input instance.
        drive_b(1'b0, 4'd13, 1'b1, 1'b1, 1'b0);
        tick();
        chk("oor13_valid", 32'(ov_b), 32'd1);
        chk("oor13_data", od_b, 32'd0);
        chk("oor13_err", 32'(err_b), 32'd1);
        chk("oor13_col", 32'(oc_b), 32'd13);
        drive_b(1'b0, 4'd3, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ok3_err", 32'(err_b), 32'd0);
        chk("ok3_data", od_b, 32'hBEEF_0003);
        drive_b(1'b0, 4'd12, 1'b1, 1'b1, 1'b0);
        tick();
        chk("oor12_err", 32'(err_b), 32'd1);
        drive_b(1'b0, 4'd11, 1'b1, 1'b1, 1'b0);
        tick();
        chk("ok11_err", 32'(err_b), 32'd0);
        chk("ok11_data", od_b, 32'hBEEF_000B);
        drive_b(1'b1, 4'd0, 1'b0, 1'b1, 1'b1);
        tick();
        for (int i = 0; i < 13; i++) begin
            drive_b(1'b1, 4'd0, 1'b1, 1'b1, 1'b0);
            tick();
            chk("scan12_col", 32'(oc_b), i % 12);
            chk("scan12_err", 32'(err_b), 32'd0);
        end

        // Randomized traffic on both instances against the model.
        for (int i = 0; i < 400; i++) begin
            fill_words(1'b1);
            drive_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 15) == 0));
            drive_b(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 15) == 0));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
